// File: rtl/cpu_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package cpu_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_DEPTH_WORDS = 512;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RESP = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr,
                                    input int unsigned depth_words);
    logic [WORD_W+1:0] limit;
    limit = (WORD_W + 2)'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage and the data memory.
interface dmem_responder_if;
  import cpu_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              addr_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, addr_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, addr_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, asynchronous read on the same index.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  // Store one word on the rising edge; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM stage: serves one load/store at a time after
// WAIT_CYCLES wait states, stalls the pipeline meanwhile, and dumps the whole
// memory word by word once dump_start is seen.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  dmem_responder_if.slave   bus,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [WORD_W-1:0] dump_addr,
  output logic [WORD_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [AW-1:0] LAST_IDX = '1;

  state_e            r_state,    w_state_nxt;
  logic [3:0]        r_cnt,      w_cnt_nxt;
  logic              r_write,    w_write_nxt;
  logic [AW-1:0]     r_idx,      w_idx_nxt;
  logic [WORD_W-1:0] r_wdata,    w_wdata_nxt;
  logic              r_err,      w_err_nxt;
  logic [WORD_W-1:0] r_rdata,    w_rdata_nxt;
  logic [AW-1:0]     r_dump_idx, w_dump_idx_nxt;

  logic              w_mem_we;
  logic [AW-1:0]     w_mem_idx;
  logic [WORD_W-1:0] w_mem_rdata;
  logic [WORD_W-1:0] w_rsp_rdata;
  logic              w_stall;

  // State and request-latch registers; reset leaves the memory untouched.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_dump_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_write    <= w_write_nxt;
      r_idx      <= w_idx_nxt;
      r_wdata    <= w_wdata_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_dump_idx <= w_dump_idx_nxt;
    end
  end

  // Next-state logic: accept, count wait states, respond, then dump on halt.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_write_nxt    = r_write;
    w_idx_nxt      = r_idx;
    w_wdata_nxt    = r_wdata;
    w_err_nxt      = r_err;
    w_rdata_nxt    = r_rdata;
    w_dump_idx_nxt = r_dump_idx;
    case (r_state)
      ST_IDLE: begin
        if (dump_start) begin
          // A request arriving together with the halt is dropped.
          w_state_nxt    = ST_DUMP;
          w_dump_idx_nxt = '0;
        end else if (bus.req_valid) begin
          w_write_nxt = bus.req_write;
          w_idx_nxt   = bus.req_addr[AW+1:2];
          w_wdata_nxt = bus.req_wdata;
          w_err_nxt   = addr_bad(bus.req_addr, DEPTH_WORDS);
          w_cnt_nxt   = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        // Never re-accept here: req_valid still belongs to the finished access.
        w_state_nxt = ST_IDLE;
        w_rdata_nxt = w_rsp_rdata;
      end
      ST_DUMP: begin
        if (r_dump_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_dump_idx_nxt = r_dump_idx + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response data: live word during RESP, otherwise the last response held.
  always_comb begin
    w_rsp_rdata = r_rdata;
    if (r_state == ST_RESP) begin
      if (r_err) begin
        w_rsp_rdata = '0;
      end else if (r_write) begin
        w_rsp_rdata = r_rdata;
      end else begin
        w_rsp_rdata = w_mem_rdata;
      end
    end else begin
      w_rsp_rdata = r_rdata;
    end
  end

  // Freeze the pipeline while a request is pending or in flight, and after halt.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:                   w_stall = bus.req_valid & ~RESET;
      ST_WAIT, ST_DUMP, ST_DONE: w_stall = 1'b1;
      ST_RESP:                   w_stall = 1'b0;
      default:                   w_stall = 1'b0;
    endcase
  end

  // The single RAM port serves the dump walk or the latched request address.
  assign w_mem_idx = (r_state == ST_DUMP) ? r_dump_idx : r_idx;
  assign w_mem_we  = (r_state == ST_RESP) & r_write & ~r_err & ~RESET;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_mem_we),
    .i_idx   (w_mem_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign bus.stall     = w_stall;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = w_rsp_rdata;
  assign bus.addr_err  = (r_state == ST_RESP) & r_err;

  assign dump_valid = (r_state == ST_DUMP);
  assign dump_addr  = (r_state == ST_DUMP) ? WORD_W'({r_dump_idx, 2'b00}) : '0;
  assign dump_data  = (r_state == ST_DUMP) ? w_mem_rdata : '0;
  assign dump_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance A (512 words, 2 wait states) and
// instance B (16 words, no wait states) against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH_A = 512;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_B = 16;
  localparam int WAIT_B  = 0;
  localparam int NV      = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_start_a, dump_valid_a, dump_done_a;
  logic [31:0] dump_addr_a, dump_data_a;
  logic        dump_start_b, dump_valid_b, dump_done_b;
  logic [31:0] dump_addr_b, dump_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl_a [DEPTH_A];
  logic [31:0] mdl_b [DEPTH_B];

  typedef struct packed {
    logic        stall;
    logic        rsp_valid;
    logic        addr_err;
    logic        dump_valid;
    logic        dump_done;
    logic [31:0] rsp_rdata;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
  } outs_t;

  typedef struct {
    int          which;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [NV];

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
    .CLK(clk), .RESET(rst), .bus(bus_a),
    .dump_start(dump_start_a), .dump_valid(dump_valid_a), .dump_addr(dump_addr_a),
    .dump_data(dump_data_a), .dump_done(dump_done_a)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
    .CLK(clk), .RESET(rst), .bus(bus_b),
    .dump_start(dump_start_b), .dump_valid(dump_valid_b), .dump_addr(dump_addr_b),
    .dump_data(dump_data_b), .dump_done(dump_done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference rule: word aligned and inside the byte range of the memory.
  function automatic bit ref_bad(input logic [31:0] addr, input int depth);
    longint a;
    a = longint'(addr);
    return ((a % 64'sd4) != 64'sd0) || (a >= 64'sd4 * longint'(depth));
  endfunction

  function automatic outs_t get_outs(input int which);
    outs_t o;
    if (which == 0) begin
      o = '{bus_a.stall, bus_a.rsp_valid, bus_a.addr_err, dump_valid_a, dump_done_a,
            bus_a.rsp_rdata, dump_addr_a, dump_data_a};
    end else begin
      o = '{bus_b.stall, bus_b.rsp_valid, bus_b.addr_err, dump_valid_b, dump_done_b,
            bus_b.rsp_rdata, dump_addr_b, dump_data_b};
    end
    return o;
  endfunction

  task automatic drive(input int which, input logic v, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (which == 0) begin
      bus_a.req_valid = v; bus_a.req_write = wr; bus_a.req_addr = addr; bus_a.req_wdata = wd;
    end else begin
      bus_b.req_valid = v; bus_b.req_write = wr; bus_b.req_addr = addr; bus_b.req_wdata = wd;
    end
  endtask

  task automatic chk_all_zero(input int which, input string tag);
    outs_t o;
    o = get_outs(which);
    chk({tag, " stall"},      32'(o.stall),      32'd0);
    chk({tag, " rsp_valid"},  32'(o.rsp_valid),  32'd0);
    chk({tag, " addr_err"},   32'(o.addr_err),   32'd0);
    chk({tag, " rsp_rdata"},  o.rsp_rdata,       32'd0);
    chk({tag, " dump_valid"}, 32'(o.dump_valid), 32'd0);
    chk({tag, " dump_addr"},  o.dump_addr,       32'd0);
    chk({tag, " dump_data"},  o.dump_data,       32'd0);
    chk({tag, " dump_done"},  32'(o.dump_done),  32'd0);
  endtask

  // One access from acceptance to response; call right after a posedge (+1).
  task automatic acc(input int which, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic exp_err, input logic chk_rd,
                     input logic [31:0] exp_rd, input string tag);
    int    w;
    bit    seen;
    outs_t o;
    w = (which == 0) ? WAIT_A : WAIT_B;
    drive(which, 1'b1, wr, addr, wd);
    seen = 1'b0;
    for (int n = 0; n < 24 && !seen; n++) begin
      @(negedge clk);
      o = get_outs(which);
      if (o.rsp_valid) begin
        seen = 1'b1;
        chk({tag, " latency"},    32'(n),          32'(w + 1));
        chk({tag, " stall_resp"}, 32'(o.stall),    32'd0);
        chk({tag, " addr_err"},   32'(o.addr_err), 32'(exp_err));
        if (chk_rd) begin
          chk({tag, " rdata"}, o.rsp_rdata, exp_rd);
        end
      end else begin
        chk({tag, " stall"}, 32'(o.stall), 32'd1);
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end
    drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t o;

    tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b1, 32'h0000_0006, 32'h1111_1111, 1'b1, 32'h0};
    tbl[5]  = '{0, 1'b1, 32'h0000_0800, 32'h2222_2222, 1'b1, 32'h0};
    tbl[6]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_C0DE};
    tbl[8]  = '{0, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
    tbl[9]  = '{0, 1'b1, 32'h0000_07FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
    tbl[10] = '{0, 1'b0, 32'h0000_07FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
    tbl[11] = '{0, 1'b0, 32'h0000_0800, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
    tbl[13] = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[14] = '{1, 1'b1, 32'h0000_0000, 32'h1357_9BDF, 1'b0, 32'h0};
    tbl[15] = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1357_9BDF};
    tbl[16] = '{1, 1'b1, 32'h0000_003C, 32'h0F0F_0F0F, 1'b0, 32'h0};
    tbl[17] = '{1, 1'b0, 32'h0000_003C, 32'h0,         1'b0, 32'h0F0F_0F0F};
    tbl[18] = '{1, 1'b1, 32'h0000_0040, 32'h7777_7777, 1'b1, 32'h0};
    tbl[19] = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1357_9BDF};

    // Reset: stall must stay low under RESET even with a request present.
    rst = 1'b1;
    dump_start_a = 1'b0;
    dump_start_b = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    o = get_outs(0);
    chk("rst stall_a", 32'(o.stall), 32'd0);
    o = get_outs(1);
    chk("rst stall_b", 32'(o.stall), 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero(0, "reset_a");
    chk_all_zero(1, "reset_b");
    @(posedge clk); #1;

    // Fill memory A with random words so every later read has a known value.
    for (int k = 0; k < DEPTH_A; k++) begin
      logic [31:0] wd;
      wd = $urandom();
      acc(0, 1'b1, 32'(k) * 32'd4, wd, 1'b0, 1'b0, 32'd0, "preload");
      mdl_a[k] = wd;
    end

    // Directed vectors, applied back to back.
    for (int i = 0; i < NV; i++) begin
      acc(tbl[i].which, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_err, !tbl[i].wr,
          tbl[i].exp_rd, $sformatf("vec%0d", i));
      if (tbl[i].which == 0 && tbl[i].wr && !tbl[i].exp_err) begin
        mdl_a[int'(tbl[i].addr >> 2)] = tbl[i].wd;
      end
    end

    // Held response data: last good load is kept, an error forces zero.
    @(negedge clk);
    o = get_outs(0);
    chk("hold rdata", o.rsp_rdata, 32'hDEAD_BEEF);
    chk("hold rsp_valid", 32'(o.rsp_valid), 32'd0);
    chk("hold stall", 32'(o.stall), 32'd0);
    @(posedge clk); #1;
    acc(0, 1'b0, 32'h0000_0803, 32'd0, 1'b1, 1'b1, 32'd0, "err_load");
    @(negedge clk);
    o = get_outs(0);
    chk("hold err rdata", o.rsp_rdata, 32'd0);
    @(posedge clk); #1;

    // Random accesses against the word-array model.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
      logic        wr;
      bit          bad;
      int          kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 7) begin
        addr = 32'($urandom_range(0, DEPTH_A - 1)) * 32'd4;
      end else if (kind == 7) begin
        addr = 32'($urandom_range(0, DEPTH_A - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      end else begin
        addr = 32'(4 * DEPTH_A) + $urandom_range(0, 4000);
      end
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom();
      bad = ref_bad(addr, DEPTH_A);
      if (bad || wr) begin
        exp = 32'd0;
      end else begin
        exp = mdl_a[int'(addr >> 2)];
      end
      acc(0, wr, addr, wd, bad, !wr, exp, "rnd");
      if (wr && !bad) begin
        mdl_a[int'(addr >> 2)] = wd;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // RESET during the wait states of a store discards it.
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero(0, "midreset");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      o = get_outs(0);
      chk("midreset no_rsp", 32'(o.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    acc(0, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, mdl_a[8], "after_reset_load");

    // Dump with a simultaneous request: request dropped, full walk, then DONE.
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
    dump_start_a = 1'b1;
    @(negedge clk);
    o = get_outs(0);
    chk("dump0 dump_valid", 32'(o.dump_valid), 32'd0);
    @(posedge clk); #1;
    dump_start_a = 1'b0;
    for (int k = 0; k < DEPTH_A; k++) begin
      dump_start_a = (k == 100);
      @(negedge clk);
      o = get_outs(0);
      chk($sformatf("dump%0d valid", k), 32'(o.dump_valid), 32'd1);
      chk($sformatf("dump%0d addr", k), o.dump_addr, 32'(k) * 32'd4);
      chk($sformatf("dump%0d data", k), o.dump_data, mdl_a[k]);
      chk($sformatf("dump%0d rsp_valid", k), 32'(o.rsp_valid), 32'd0);
      chk($sformatf("dump%0d stall", k), 32'(o.stall), 32'd1);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      dump_start_a = (k == 2);
      @(negedge clk);
      o = get_outs(0);
      chk("done dump_valid", 32'(o.dump_valid), 32'd0);
      chk("done dump_done", 32'(o.dump_done), 32'd1);
      chk("done stall", 32'(o.stall), 32'd1);
      chk("done rsp_valid", 32'(o.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    dump_start_a = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero(0, "post_dump_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target side of the MEM-stage data-memory interface: accepts one load/store request at a time from the pipeline's memory stage and serves it after a configurable number of wait states.
- Drives a stall back to the pipeline registers while the request is in flight.
- Holds the word-addressed data storage.
- On halt, streams the whole memory contents out word by word for the bench to dump.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words stored; power of two.
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage holds a load or store; held stable while stall=1.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- stall  out  1  freeze IF/ID/EX/MEM pipeline registers.
- rsp_valid  out  1  one-cycle pulse: request completed this cycle.
- rsp_rdata  out  32  load data; valid with rsp_valid.
- addr_err  out  1  pulses with rsp_valid for a misaligned or out-of-range access.
- dump_start  in  1  halt detected; begin dump.
- dump_valid  out  1  dump_addr/dump_data valid this cycle.
- dump_addr  out  32  byte address of the word being dumped.
- dump_data  out  32  memory word at dump_addr.
- dump_done  out  1  high after the last dump word; held until RESET.

Behaviour:
- Clock and reset: one clock (CLK). RESET is synchronous and active-high. RESET has priority over all inputs.
- Reset values: state=IDLE; stall, rsp_valid, rsp_rdata, addr_err, dump_valid, dump_addr, dump_data and dump_done are all 0.
- Reset does not clear memory. An in-flight store is discarded if RESET arrives before RESP.
- FSM states: IDLE, WAIT, RESP, DUMP, DONE.
- IDLE:
  - dump_start=1 -> DUMP. dump_start wins over a simultaneous req_valid; that request is dropped.
  - Otherwise req_valid=1 -> latch write/addr/wdata. Go to WAIT with cnt=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: cnt decrements each cycle; at cnt=0 -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - A store writes memory at this clock edge.
  - A load drives rsp_rdata with the word read from the latched address.
  - Unconditionally -> IDLE. The req_valid still asserted from the same instruction is not re-accepted in RESP.
  - The pipeline advances at the end of RESP.
- stall (combinational): 1 when (IDLE and req_valid and not RESET), in WAIT, in DUMP, or in DONE. 0 in RESP.
- Latency: request seen in cycle 0 -> rsp_valid in cycle WAIT_CYCLES+1. stall is high in cycles 0..WAIT_CYCLES.
- Next request: back-to-back requests are accepted in the IDLE cycle after RESP. This gives WAIT_CYCLES+2 cycles per access.
- Addressing: word index = req_addr[2+log2(DEPTH_WORDS)-1:2].
- Access error: raised when req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS. In RESP: addr_err=1, the write is suppressed, rsp_rdata=0.
- rsp_rdata is held between responses; it is 0 only after reset or an error.
- DUMP:
  - dump_valid=1 for DEPTH_WORDS consecutive cycles.
  - dump_addr = 0, 4, 8, ..., 4*(DEPTH_WORDS-1); dump_data = mem at that address.
  - After the last word -> DONE.
  - req_valid is ignored during DUMP.
- DONE: dump_valid=0, dump_done=1, stall=1; held until RESET.
- A second dump_start in DUMP or DONE has no effect.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (IDLE, WAIT, RESP, DUMP, DONE);
  - WORD_W=32;
  - the default DEPTH_WORDS and WAIT_CYCLES constants.
- One natural sub-module: dmem_array. It is a single-port synchronous word RAM with write enable and an asynchronous read index. It is reused for both request service and dump.

Test Plan:
- Store 0xDEADBEEF to addr 0x10, then load from 0x10 (WAIT_CYCLES=2) -> each access: stall high 3 cycles, rsp_valid in cycle 3; load rsp_rdata=0xDEADBEEF, addr_err=0.
- WAIT_CYCLES=0: load from 0x0 after reset -> stall for the acceptance cycle only, rsp_valid on the next cycle. Back-to-back loads complete every 2 cycles.
- Store to 0x6 (misaligned), then store to 0x800 (out of range, DEPTH_WORDS=512) -> each gives rsp_valid=1 with addr_err=1; memory unchanged; a subsequent load from 0x4 returns the prior value.
- RESET asserted during WAIT of a store of 0x12345678 to 0x20 -> next cycle all outputs are 0; a later load from 0x20 returns the old value.
- Preload words 0..3 via stores, then pulse dump_start together with req_valid -> request dropped; dump_addr 0x0, 0x4, ... with matching data for 512 cycles; then dump_done=1 and stall=1 persist.
